// File: rtl/fp_ctrl_pkg.sv
// Shared constants and the round-robin arbitration helper for the FPU
// multiplier sequencer.
package fp_ctrl_pkg;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Number of requesters sharing the multiplier
  localparam int NUM_REQ = 2;

  // IEEE-754 single-precision constants
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  // One-hot grant: a lone requester wins; on a tie the requester that was
  // not granted last wins.
  function automatic logic [NUM_REQ-1:0] arb_grant(
    input logic [NUM_REQ-1:0] valid,
    input logic               last_grant
  );
    logic [NUM_REQ-1:0] grant;
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
    return grant;
  endfunction

endpackage

// File: rtl/fp_mul_32.sv
// Combinational single-precision multiplier. A zero exponent field on
// either operand flushes the product to zero; NaN/Inf are not treated
// specially and exponent overflow simply wraps.
module fp_mul_32
  import fp_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);

  logic [47:0] prod;
  logic [46:0] norm;
  logic [22:0] mant;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_rnd;
  logic [7:0]  exp_res;

  // Multiply significands, normalise, round to nearest even, rebias exponent
  always_comb begin
    prod     = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    norm     = prod[47] ? prod[46:0] : {prod[45:0], 1'b0};
    mant     = norm[46:24];
    guard    = norm[23];
    sticky   = |norm[22:0];
    round_up = guard & (sticky | mant[0]);
    // A rounding carry out leaves the fraction at zero and bumps the exponent
    mant_rnd = {1'b0, mant} + {23'b0, round_up};
    exp_res  = a[30:23] + b[30:23] - 8'd127 + {7'b0, prod[47]} + {7'b0, mant_rnd[23]};
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
      p = FP_ZERO;
    end else begin
      p = {a[31] ^ b[31], exp_res, mant_rnd[22:0]};
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Two-port round-robin sequencer for the shared combinational multiplier:
// accepts one operand pair, holds it for CALC_CYCLES, captures the product
// and returns it to the granted requester.
module fp_mul_arbiter
  import fp_ctrl_pkg::*;
#(
  parameter int CALC_CYCLES = 1,
  parameter int FIRST_GRANT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [31:0]        req_a0,
  input  logic [31:0]        req_b0,
  input  logic [31:0]        req_a1,
  input  logic [31:0]        req_b1,
  output logic [NUM_REQ-1:0] rsp_valid,
  input  logic [NUM_REQ-1:0] rsp_ready,
  output logic [31:0]        rsp_result,
  output logic               busy
);

  localparam logic [3:0] CNT_LOAD = 4'(CALC_CYCLES - 1);
  localparam logic       FG       = 1'(FIRST_GRANT);

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               cur_id_q, cur_id_d;
  logic               last_grant_q, last_grant_d;
  logic [31:0]        op_a_q, op_a_d;
  logic [31:0]        op_b_q, op_b_d;
  logic [31:0]        rsp_result_q, rsp_result_d;
  logic [NUM_REQ-1:0] grant_oh;
  logic [31:0]        mul_p;

  assign grant_oh = arb_grant(req_valid, last_grant_q);

  fp_mul_32 u_mul (
    .a (op_a_q),
    .b (op_b_q),
    .p (mul_p)
  );

  // State register; last_grant resets to the loser so FIRST_GRANT wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      cur_id_q     <= 1'b0;
      last_grant_q <= ~FG;
      op_a_q       <= FP_ZERO;
      op_b_q       <= FP_ZERO;
      rsp_result_q <= FP_ZERO;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_id_q     <= cur_id_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  // Next-state: grant and latch in IDLE, count down in CALC, wait for handshake in RESP
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_id_d     = cur_id_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rsp_result_d = rsp_result_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant_oh) begin
          op_a_d   = grant_oh[1] ? req_a1 : req_a0;
          op_b_d   = grant_oh[1] ? req_b1 : req_b0;
          cur_id_d = grant_oh[1];
          cnt_d    = CNT_LOAD;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_result_d = mul_p;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready[cur_id_q]) begin
          last_grant_d = cur_id_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: ready only while idle and out of reset, response one-hot in RESP
  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    busy       = (state_q != ST_IDLE);
    rsp_result = rsp_result_q;
    if (state_q == ST_IDLE && !reset) begin
      req_ready = grant_oh;
    end
    if (state_q == ST_RESP) begin
      rsp_valid[cur_id_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
module tb_fp_mul_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A: CALC_CYCLES=1, FIRST_GRANT=0
  logic [1:0]  a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic [31:0] a_a0, a_b0, a_a1, a_b1, a_rsp_result;
  logic        a_busy;

  // Instance B: CALC_CYCLES=4, FIRST_GRANT=1
  logic [1:0]  b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [31:0] b_a0, b_b0, b_a1, b_b1, b_rsp_result;
  logic        b_busy;

  fp_mul_arbiter #(.CALC_CYCLES(1), .FIRST_GRANT(0)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_a0(a_a0), .req_b0(a_b0), .req_a1(a_a1), .req_b1(a_b1),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_result(a_rsp_result), .busy(a_busy)
  );

  fp_mul_arbiter #(.CALC_CYCLES(4), .FIRST_GRANT(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_a0(b_a0), .req_b0(b_b0), .req_a1(b_a1), .req_b1(b_b1),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_result(b_rsp_result), .busy(b_busy)
  );

  int checks = 0;
  int failures = 0;
  logic last_g;   // model: requester of A granted most recently (reset: ~FIRST_GRANT)

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Exact single-precision product for operands whose product fits in 24 bits
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, prod;
    int e;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0;
    ma = 0; ma[23:0] = {1'b1, a[22:0]};
    mb = 0; mb[23:0] = {1'b1, b[22:0]};
    prod = ma * mb;
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod >= (64'd1 << 47)) begin
      e = e + 1;
      prod = prod >> 24;
    end else begin
      prod = prod >> 23;
    end
    return {a[31] ^ b[31], e[7:0], prod[22:0]};
  endfunction

  // Random operand: short significand so products are exact, sometimes zero exponent
  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r[31]    = 1'($urandom_range(0, 1));
    r[30:23] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(100, 150));
    r[22:0]  = {8'($urandom_range(0, 255)), 15'b0};
    return r;
  endfunction

  // One full transaction on instance A, checked against the model
  task automatic run_op(input logic [1:0] valid, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1, input int hold,
                        output int g, output logic [31:0] res);
    int n, lat;
    logic [1:0] exp_oh;
    logic [31:0] exp_r;
    a_req_valid = valid;
    a_a0 = a0; a_b0 = b0; a_a1 = a1; a_b1 = b1;
    #1;
    n = 0;
    while (a_req_ready == 2'b00 && n < 20) begin
      cyc(); #1; n++;
    end
    chk("grant_wait", n, 0);
    if (valid == 2'b01) g = 0;
    else if (valid == 2'b10) g = 1;
    else g = last_g ? 0 : 1;
    exp_oh = 2'b01 << g;
    exp_r = (g == 1) ? ref_mul(a1, b1) : ref_mul(a0, b0);
    chk("req_ready", a_req_ready, exp_oh);
    $display("txn valid=%b grant=%0d a=%08h b=%08h expect=%08h", valid, g,
             (g == 1) ? a1 : a0, (g == 1) ? b1 : b0, exp_r);
    cyc();
    a_req_valid[g] = 1'b0;
    if (g == 1) begin a_a1 = rand_fp(); a_b1 = rand_fp(); end
    else begin a_a0 = rand_fp(); a_b0 = rand_fp(); end
    #1;
    lat = 1;
    while (a_rsp_valid == 2'b00 && lat < 30) begin
      chk("calc_busy", a_busy, 1);
      chk("calc_req_ready", a_req_ready, 0);
      cyc(); #1; lat++;
    end
    chk("latency", lat, 2);
    chk("rsp_valid", a_rsp_valid, exp_oh);
    chk("rsp_result", a_rsp_result, exp_r);
    res = a_rsp_result;
    a_rsp_ready = ~exp_oh;   // the other requester's ready must be ignored
    for (int i = 0; i < hold; i++) begin
      cyc(); #1;
      chk("hold_valid", a_rsp_valid, exp_oh);
      chk("hold_result", a_rsp_result, exp_r);
      chk("hold_busy", a_busy, 1);
      chk("resp_req_ready", a_req_ready, 0);
    end
    a_rsp_ready = 2'b11;
    cyc();
    a_rsp_ready = 2'b00;
    #1;
    last_g = 1'(g);
    chk("idle_rsp_valid", a_rsp_valid, 0);
    chk("idle_busy", a_busy, 0);
    chk("followup_ready", a_req_ready, a_req_valid);
  endtask

  // Wait for instance B's response, returning cycles since the grant cycle
  task automatic wait_b(output int lat);
    lat = 1;
    while (b_rsp_valid == 2'b00 && lat < 40) begin
      chk("b_calc_busy", b_busy, 1);
      cyc(); #1; lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, lat;
    logic [31:0] res;

    reset = 1'b1;
    a_req_valid = 2'b11; a_rsp_ready = 2'b00;
    a_a0 = 0; a_b0 = 0; a_a1 = 0; a_b1 = 0;
    b_req_valid = 2'b00; b_rsp_ready = 2'b00;
    b_a0 = 0; b_b0 = 0; b_a1 = 0; b_b1 = 0;
    last_g = 1'b1;
    cyc(); cyc(); #1;
    chk("rst_req_ready", a_req_ready, 0);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_result", a_rsp_result, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_b_busy", b_busy, 0);
    a_req_valid = 2'b00;
    reset = 1'b0;
    cyc();

    // Instance B: first tie goes to requester 1, 4 compute cycles, operands latched
    b_req_valid = 2'b11;
    b_a0 = 32'h3F800000; b_b0 = 32'h40A00000;
    b_a1 = 32'h40000000; b_b1 = 32'h40800000;
    #1;
    chk("b_first_tie", b_req_ready, 2'b10);
    cyc();
    b_req_valid = 2'b01;
    b_a1 = rand_fp(); b_b1 = rand_fp();
    #1;
    wait_b(lat);
    chk("b_latency", lat, 5);
    chk("b_rsp_valid", b_rsp_valid, 2'b10);
    chk("b_result", b_rsp_result, 32'h41000000);
    $display("txn b grant=1 latency=%0d result=%08h", lat, b_rsp_result);
    b_rsp_ready = 2'b11;
    cyc(); #1;
    chk("b_followup_ready", b_req_ready, 2'b01);
    cyc();
    b_req_valid = 2'b00;
    #1;
    wait_b(lat);
    chk("b_latency2", lat, 5);
    chk("b_rsp_valid2", b_rsp_valid, 2'b01);
    chk("b_result2", b_rsp_result, 32'h40A00000);
    $display("txn b grant=0 latency=%0d result=%08h", lat, b_rsp_result);
    cyc();
    b_rsp_ready = 2'b00;
    #1;
    chk("b_idle_busy", b_busy, 0);

    // Instance A directed vectors
    run_op(2'b01, 32'h40000000, 32'h40400000, 0, 0, 0, g, res);
    chk("r0_2x3", res, 32'h40C00000);
    run_op(2'b10, 0, 0, 32'h3FC00000, 32'h3FC00000, 5, g, res);
    chk("r1_1p5sq", res, 32'h40100000);

    // Both requesting continuously: grants alternate
    for (int i = 0; i < 4; i++) begin
      run_op(2'b11, 32'hC0000000, 32'h40400000, 32'h00000000, 32'h3F800000, 0, g, res);
      chk("alt_grant", g, i % 2);
      chk("alt_result", res, (i % 2 == 0) ? 32'hC0C00000 : 32'h00000000);
    end

    // Randomised transactions against the model
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(1, 3)), rand_fp(), rand_fp(), rand_fp(), rand_fp(),
             int'($urandom_range(0, 3)), g, res);
    end
    a_req_valid = 2'b00;
    cyc();

    // Reset during CALC
    a_req_valid = 2'b01; a_a0 = 32'h40000000; a_b0 = 32'h40000000;
    #1;
    chk("rc_grant", a_req_ready, 2'b01);
    cyc();
    a_req_valid = 2'b00;
    reset = 1'b1;
    cyc(); #1;
    chk("rc_rsp_valid", a_rsp_valid, 0);
    chk("rc_busy", a_busy, 0);
    chk("rc_result", a_rsp_result, 0);
    chk("rc_req_ready", a_req_ready, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("rc_no_rsp", a_rsp_valid, 0);
    end

    // Reset during RESP
    a_req_valid = 2'b10; a_a1 = 32'h40400000; a_b1 = 32'h40400000;
    #1;
    chk("rr_grant", a_req_ready, 2'b10);
    cyc();
    a_req_valid = 2'b00;
    cyc(); #1;
    chk("rr_in_resp", a_rsp_valid, 2'b10);
    chk("rr_resp_result", a_rsp_result, 32'h41100000);
    reset = 1'b1;
    cyc(); #1;
    chk("rr_rsp_valid", a_rsp_valid, 0);
    chk("rr_busy", a_busy, 0);
    chk("rr_result", a_rsp_result, 0);
    reset = 1'b0;
    last_g = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("rr_no_rsp", a_rsp_valid, 0);
    end

    // First tie after reset goes to FIRST_GRANT
    run_op(2'b11, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000, 0, g, res);
    chk("post_reset_tie", g, 0);
    chk("post_reset_result", res, 32'h3F800000);
    a_req_valid = 2'b00;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
